minisys_mem_stage: RTL and testbench

// MEM stage of the Minisys pipeline. Consumes the EX/MEM register outputs:
//   - ALU result as address, store data, byte-write enables, load-type flags.

---
 rtl/minisys_mem_stage.sv | 176 +++++++++++++++++
 tb/tb_minisys_mem_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/minisys_mem_stage.sv
// Minisys MEM stage: data-memory req/ack sequencing, store-lane replication,
// load extension, pipeline stall generation and the MEM/WB register.
module minisys_mem_stage #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        regwriteM,
    input  logic        mem2regM,
    input  logic        branchM,
    input  logic        jumpM,
    input  logic [3:0]  memwriteM,
    input  logic [4:0]  write_regM,
    input  logic [31:0] alu_outM,
    input  logic [31:0] write_dataM,
    input  logic [31:0] pc_branchM,
    input  logic [31:0] pcplus4M,
    input  logic        op_lbM,
    input  logic        op_lbuM,
    input  logic        op_lhM,
    input  logic        op_lhuM,
    input  logic        op_lwM,
    input  logic        write_31M,
    output logic        dmem_req,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stallM,
    output logic        pcsrcM,
    output logic        regwriteW,
    output logic        mem2regW,
    output logic        write_31W,
    output logic [4:0]  write_regW,
    output logic [31:0] alu_outW,
    output logic [31:0] read_dataW,
    output logic [31:0] pcplus4W,
    output logic        errW
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYC - 1);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_req;
    logic [3:0]    r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;

    state_t        w_state_nxt;
    logic          w_acc;
    logic          w_mis;
    logic          w_stall;
    logic          w_fault;
    logic          w_start;
    logic          w_done;
    logic [31:0]   w_wdata_rep;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load_ext;
    logic [31:0]   w_rdata_nxt;
    logic          w_unused;

    // Branch target and jump are consumed by fetch via pcsrcM; kept here only as part of the EX/MEM bundle.
    assign w_unused = ^{pc_branchM, jumpM};

    assign w_acc = mem2regM | (|memwriteM);
    assign w_mis = ((op_lhM | op_lhuM | (memwriteM == 4'b0011) | (memwriteM == 4'b1100)) & alu_outM[0])
                 | ((op_lwM | (memwriteM == 4'hF)) & (|alu_outM[1:0]));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_fault     = 1'b0;
        w_start     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_acc && !w_mis) begin
                    w_stall     = 1'b1;
                    w_start     = 1'b1;
                    w_state_nxt = S_REQ;
                end else begin
                    w_fault = w_acc & w_mis;
                end
            end
            S_REQ: begin
                // Ack takes priority over the timeout terminal count.
                if (dmem_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == LAST_CNT) begin
                    w_done      = 1'b1;
                    w_fault     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_wdata_rep = write_dataM;
        if ($countones(memwriteM) == 1)
            w_wdata_rep = {4{write_dataM[7:0]}};
        else if ($countones(memwriteM) == 2)
            w_wdata_rep = {2{write_dataM[15:0]}};
    end

    always_comb begin
        w_byte     = 8'(dmem_rdata >> {alu_outM[1:0], 3'b000});
        w_half     = alu_outM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        w_load_ext = dmem_rdata;
        if (op_lbM)       w_load_ext = {{24{w_byte[7]}}, w_byte};
        else if (op_lbuM) w_load_ext = {24'h0, w_byte};
        else if (op_lhM)  w_load_ext = {{16{w_half[15]}}, w_half};
        else if (op_lhuM) w_load_ext = {16'h0, w_half};
        w_rdata_nxt = (r_state == S_REQ && dmem_ack && mem2regM) ? w_load_ext : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_req      <= 1'b0;
            r_we       <= 4'h0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            regwriteW  <= 1'b0;
            mem2regW   <= 1'b0;
            write_31W  <= 1'b0;
            write_regW <= 5'h0;
            alu_outW   <= 32'h0;
            read_dataW <= 32'h0;
            pcplus4W   <= 32'h0;
            errW       <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
            r_state <= w_state_nxt;
            if (w_start) begin
                r_req   <= 1'b1;
                r_we    <= memwriteM;
                r_addr  <= {alu_outM[31:2], 2'b00};
                r_wdata <= w_wdata_rep;
                r_cnt   <= '0;
            end else if (r_state == S_REQ) begin
                if (w_done) r_req <= 1'b0;
                else        r_cnt <= r_cnt + CW'(1);
            end
            // A stalled cycle writes a bubble; a faulted instr retires without a register write.
            regwriteW  <= regwriteM & ~w_stall & ~w_fault;
            mem2regW   <= mem2regM & ~w_stall;
            write_31W  <= write_31M & ~w_stall;
            errW       <= w_fault;
            write_regW <= write_regM;
            alu_outW   <= alu_outM;
            pcplus4W   <= pcplus4M;
            read_dataW <= w_rdata_nxt;
        end
    end

    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign stallM     = w_stall;
    assign pcsrcM     = branchM & ~w_stall;

endmodule

// File: tb/tb_minisys_mem_stage.sv
// Directed bench for minisys_mem_stage: ALU pass-through, loads, stores,
// misalignment, timeout, ack/timeout tie and reset mid-transaction.
module tb_minisys_mem_stage;

    logic        clk = 1'b0;
    logic        clrn;
    logic        regwriteM, mem2regM, branchM, jumpM;
    logic [3:0]  memwriteM;
    logic [4:0]  write_regM;
    logic [31:0] alu_outM, write_dataM, pc_branchM, pcplus4M;
    logic        op_lbM, op_lbuM, op_lhM, op_lhuM, op_lwM, write_31M;
    logic        dmem_req;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        stallM, pcsrcM;
    logic        regwriteW, mem2regW, write_31W, errW;
    logic [4:0]  write_regW;
    logic [31:0] alu_outW, read_dataW, pcplus4W;

    int checks = 0;
    int errors = 0;

    minisys_mem_stage #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .clrn(clrn),
        .regwriteM(regwriteM), .mem2regM(mem2regM), .branchM(branchM), .jumpM(jumpM),
        .memwriteM(memwriteM), .write_regM(write_regM), .alu_outM(alu_outM),
        .write_dataM(write_dataM), .pc_branchM(pc_branchM), .pcplus4M(pcplus4M),
        .op_lbM(op_lbM), .op_lbuM(op_lbuM), .op_lhM(op_lhM), .op_lhuM(op_lhuM), .op_lwM(op_lwM),
        .write_31M(write_31M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stallM(stallM), .pcsrcM(pcsrcM),
        .regwriteW(regwriteW), .mem2regW(mem2regW), .write_31W(write_31W),
        .write_regW(write_regW), .alu_outW(alu_outW), .read_dataW(read_dataW),
        .pcplus4W(pcplus4W), .errW(errW)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        regwriteM = 0; mem2regM = 0; branchM = 0; jumpM = 0; memwriteM = 4'h0;
        write_regM = 5'h0; alu_outM = 32'h0; write_dataM = 32'h0; pc_branchM = 32'h0;
        pcplus4M = 32'h0; op_lbM = 0; op_lbuM = 0; op_lhM = 0; op_lhuM = 0; op_lwM = 0;
        write_31M = 0; dmem_ack = 0; dmem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        nop();
        repeat (2) step();
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", dmem_req); end
        checks++; if (dmem_we !== 4'h0) begin errors++; $display("FAIL reset_we: got %h expected 0", dmem_we); end
        checks++; if (dmem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", dmem_addr); end
        checks++; if (dmem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", dmem_wdata); end
        checks++; if ({regwriteW, mem2regW, write_31W, errW} !== 4'h0) begin errors++;
            $display("FAIL reset_wb_ctrl: got %b expected 0000", {regwriteW, mem2regW, write_31W, errW}); end
        checks++; if ({alu_outW, read_dataW, pcplus4W} !== 96'h0 || write_regW !== 5'h0) begin errors++;
            $display("FAIL reset_wb_data: got %h/%h/%h/%h expected all 0", alu_outW, read_dataW, pcplus4W, write_regW); end
        clrn = 1'b1;
    endtask

    task automatic test_alu();
        nop();
        regwriteM = 1; alu_outM = 32'h1234; write_regM = 5'd5; pcplus4M = 32'h44;
        branchM = 1; write_31M = 1;
        #1;
        checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b expected 0", stallM); end
        checks++; if (pcsrcM !== 1'b1) begin errors++; $display("FAIL alu_pcsrc: got %b expected 1", pcsrcM); end
        step();
        checks++; if (regwriteW !== 1'b1) begin errors++; $display("FAIL alu_regwrite: got %b expected 1", regwriteW); end
        checks++; if (alu_outW !== 32'h1234) begin errors++; $display("FAIL alu_out: got %h expected 1234", alu_outW); end
        checks++; if (write_regW !== 5'd5 || pcplus4W !== 32'h44 || write_31W !== 1'b1) begin errors++;
            $display("FAIL alu_fields: got %h/%h/%b expected 05/44/1", write_regW, pcplus4W, write_31W); end
        checks++; if (errW !== 1'b0 || read_dataW !== 32'h0 || dmem_req !== 1'b0) begin errors++;
            $display("FAIL alu_side: got err=%b rd=%h req=%b expected 0/0/0", errW, read_dataW, dmem_req); end
        nop();
    endtask

    task automatic test_lb();
        nop();
        mem2regM = 1; op_lbM = 1; regwriteM = 1; write_regM = 5'd8; alu_outM = 32'h103; branchM = 1;
        #1;
        checks++; if (stallM !== 1'b1) begin errors++; $display("FAIL lb_stall_idle: got %b expected 1", stallM); end
        checks++; if (pcsrcM !== 1'b0) begin errors++; $display("FAIL lb_pcsrc_stalled: got %b expected 0", pcsrcM); end
        step();
        checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || dmem_we !== 4'h0) begin errors++;
            $display("FAIL lb_bus: got req=%b addr=%h we=%h expected 1/100/0", dmem_req, dmem_addr, dmem_we); end
        checks++; if (regwriteW !== 1'b0 || mem2regW !== 1'b0) begin errors++;
            $display("FAIL lb_bubble: got rw=%b m2r=%b expected 0/0", regwriteW, mem2regW); end
        dmem_ack = 1; dmem_rdata = 32'h80FF_0000;
        #1;
        checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL lb_stall_ack: got %b expected 0", stallM); end
        step();
        checks++; if (read_dataW !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h expected ffffff80", read_dataW); end
        checks++; if (regwriteW !== 1'b1 || mem2regW !== 1'b1 || write_regW !== 5'd8 || dmem_req !== 1'b0) begin errors++;
            $display("FAIL lb_wb: got rw=%b m2r=%b wr=%h req=%b expected 1/1/08/0", regwriteW, mem2regW, write_regW, dmem_req); end
        nop();
    endtask

    task automatic do_load(input logic [4:0] ops, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] expv);
        nop();
        {op_lbM, op_lbuM, op_lhM, op_lhuM, op_lwM} = ops;
        mem2regM = 1; regwriteM = 1; alu_outM = addr;
        step();
        dmem_ack = 1; dmem_rdata = rdata;
        step();
        checks++; if (read_dataW !== expv || errW !== 1'b0) begin errors++;
            $display("FAIL load_ext ops=%b addr=%h: got %h err=%b expected %h err=0", ops, addr, read_dataW, errW, expv); end
        nop();
    endtask

    task automatic test_load_ext();
        do_load(5'b00100, 32'h102, 32'h8001_7FFF, 32'hFFFF_8001);
        do_load(5'b00010, 32'h102, 32'h8001_7FFF, 32'h0000_8001);
        do_load(5'b01000, 32'h101, 32'h0000_9C00, 32'h0000_009C);
        do_load(5'b00001, 32'h104, 32'hCAFE_F00D, 32'hCAFE_F00D);
    endtask

    task automatic test_sh();
        int n_stall;
        nop();
        memwriteM = 4'b1100; alu_outM = 32'h202; write_dataM = 32'hABCD_5678;
        n_stall = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) dmem_ack = 1;
            #1;
            if (stallM === 1'b1) n_stall++;
            if (c >= 1) begin
                checks++;
                if (dmem_req !== 1'b1 || dmem_we !== 4'b1100 || dmem_wdata !== 32'h5678_5678 || dmem_addr !== 32'h200) begin
                    errors++;
                    $display("FAIL sh_bus c=%0d: got req=%b we=%b wd=%h addr=%h expected 1/1100/56785678/200",
                             c, dmem_req, dmem_we, dmem_wdata, dmem_addr);
                end
            end
            step();
        end
        checks++; if (n_stall != 4) begin errors++; $display("FAIL sh_stall_cycles: got %0d expected 4", n_stall); end
        checks++; if (dmem_req !== 1'b0 || regwriteW !== 1'b0 || errW !== 1'b0) begin errors++;
            $display("FAIL sh_done: got req=%b rw=%b err=%b expected 0/0/0", dmem_req, regwriteW, errW); end
        nop();
    endtask

    task automatic test_misaligned();
        nop();
        mem2regM = 1; op_lwM = 1; regwriteM = 1; alu_outM = 32'h106;
        #1;
        checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL mis_lw_stall: got %b expected 0", stallM); end
        step();
        checks++; if (dmem_req !== 1'b0 || errW !== 1'b1 || regwriteW !== 1'b0) begin errors++;
            $display("FAIL mis_lw: got req=%b err=%b rw=%b expected 0/1/0", dmem_req, errW, regwriteW); end
        nop();
        memwriteM = 4'b0011; alu_outM = 32'h201; write_dataM = 32'h1;
        step();
        checks++; if (dmem_req !== 1'b0 || errW !== 1'b1) begin errors++;
            $display("FAIL mis_sh: got req=%b err=%b expected 0/1", dmem_req, errW); end
        nop();
        step();
        checks++; if (errW !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b expected 0", errW); end
    endtask

    task automatic test_timeout();
        int n;
        nop();
        mem2regM = 1; op_lwM = 1; regwriteM = 1; alu_outM = 32'h300;
        step();
        n = 0;
        while (dmem_req === 1'b1 && n < 40) begin
            n++;
            step();
        end
        checks++; if (n != 16) begin errors++; $display("FAIL timeout_req_cycles: got %0d expected 16", n); end
        checks++; if (errW !== 1'b1 || regwriteW !== 1'b0 || dmem_req !== 1'b0 || read_dataW !== 32'h0) begin errors++;
            $display("FAIL timeout_wb: got err=%b rw=%b req=%b rd=%h expected 1/0/0/0", errW, regwriteW, dmem_req, read_dataW); end
        nop();
        #1;
        checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL timeout_idle: got stall %b expected 0", stallM); end
        step();
    endtask

    task automatic test_timeout_ack_tie();
        nop();
        mem2regM = 1; op_lwM = 1; regwriteM = 1; alu_outM = 32'h304; write_regM = 5'd3;
        step();
        repeat (15) step();
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL tie_req_last: got %b expected 1", dmem_req); end
        dmem_ack = 1; dmem_rdata = 32'h1111_2222;
        #1;
        checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL tie_stall: got %b expected 0", stallM); end
        step();
        checks++; if (errW !== 1'b0 || regwriteW !== 1'b1 || read_dataW !== 32'h1111_2222 || dmem_req !== 1'b0) begin errors++;
            $display("FAIL tie_wb: got err=%b rw=%b rd=%h req=%b expected 0/1/11112222/0", errW, regwriteW, read_dataW, dmem_req); end
        nop();
    endtask

    task automatic test_reset_mid();
        nop();
        mem2regM = 1; op_lwM = 1; regwriteM = 1; alu_outM = 32'h400; write_regM = 5'd9;
        step();
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rstmid_req_before: got %b expected 1", dmem_req); end
        clrn = 1'b0;
        nop();
        step();
        checks++; if (dmem_req !== 1'b0 || {regwriteW, mem2regW, write_31W, errW} !== 4'h0 || write_regW !== 5'h0) begin errors++;
            $display("FAIL rstmid_after: got req=%b ctrl=%b wr=%h expected 0/0000/00", dmem_req,
                     {regwriteW, mem2regW, write_31W, errW}, write_regW); end
        clrn = 1'b1;
        dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b expected 0", stallM); end
        step();
        checks++; if (dmem_req !== 1'b0 || read_dataW !== 32'h0 || regwriteW !== 1'b0 || errW !== 1'b0) begin errors++;
            $display("FAIL rstmid_late_ack: got req=%b rd=%h rw=%b err=%b expected 0/0/0/0", dmem_req, read_dataW, regwriteW, errW); end
        nop();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lb();
        test_load_ext();
        test_sh();
        test_misaligned();
        test_timeout();
        test_timeout_ack_tie();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
